// File: rtl/sdram_pkg.sv
// Shared sizing, FSM encodings and refresh-interval derivation for the SDRAM arbiter.
package sdram_pkg;

  localparam int ADDR_WIDTH = 25;
  localparam int DATA_WIDTH = 16;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // Cycles between refreshes; integer MHz keeps the result exact for common clocks.
  function automatic int unsigned refresh_interval(input int unsigned freq_hz,
                                                   input int unsigned period_us);
    return freq_hz / 1_000_000 * period_us;
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh timer that accumulates a saturating 4-bit refresh debt
// and flags a sticky overrun when a wrap finds the debt already full.
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int unsigned INTERVAL = 810
) (
  input  logic clk,
  input  logic reset,
  input  logic consume,
  output logic due,
  output logic overrun
);

  localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  logic [CW-1:0] r_count;
  logic [3:0]    r_debt;
  logic          r_overrun;
  logic          w_wrap;

  assign w_wrap  = (r_count == CW'(INTERVAL - 1));
  assign due     = (r_debt != 4'd0);
  assign overrun = r_overrun;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_debt    <= 4'd0;
      r_overrun <= 1'b0;
    end else begin
      r_count <= w_wrap ? '0 : r_count + CW'(1);
      // A wrap and a consumed refresh in the same cycle cancel out.
      if (w_wrap && !consume) begin
        if (r_debt == 4'hF) r_overrun <= 1'b1;
        else                r_debt    <= r_debt + 4'd1;
      end else if (!w_wrap && consume && (r_debt != 4'd0)) begin
        r_debt <= r_debt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of an SDRAM controller; pending refreshes
// take priority, and one command is in flight until the controller drops busy.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned FREQ       = 54_000_000,
  parameter int unsigned REFRESH_US = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_rvalid,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_rvalid,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  mem_refresh,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_data_ready,
  input  logic                  mem_busy,
  output logic                  refresh_overrun
);

  localparam int unsigned REFRESH_INTERVAL = refresh_interval(FREQ, REFRESH_US);

  logic [1:0]            r_state;
  logic                  r_last_p1;
  logic                  r_gnt_p1;
  logic                  r_op_we;
  logic                  r_op_ref;
  logic                  r_mem_rd, r_mem_wr, r_mem_refresh;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_din;
  logic                  r_p0_ack, r_p1_ack, r_p0_rvalid, r_p1_rvalid;
  logic [DATA_WIDTH-1:0] r_p0_rdata, r_p1_rdata;

  logic                  w_due, w_overrun, w_idle_free, w_grant_ref, w_grant_port;
  logic                  w_pick_p1, w_sel_we, w_read_return;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  sdram_refresh_timer #(
    .INTERVAL(REFRESH_INTERVAL)
  ) u_refresh (
    .clk    (clk),
    .reset  (reset),
    .consume(w_grant_ref),
    .due    (w_due),
    .overrun(w_overrun)
  );

  assign w_idle_free   = (r_state == ST_IDLE) && !mem_busy;
  assign w_grant_ref   = w_idle_free && w_due;
  assign w_grant_port  = w_idle_free && !w_due && (p0_req || p1_req);
  // With both requesting, the port that did not win last time goes next.
  assign w_pick_p1     = p1_req && (!p0_req || !r_last_p1);
  assign w_sel_we      = w_pick_p1 ? p1_we    : p0_we;
  assign w_sel_addr    = w_pick_p1 ? p1_addr  : p0_addr;
  assign w_sel_wdata   = w_pick_p1 ? p1_wdata : p0_wdata;
  assign w_read_return = (r_state != ST_IDLE) && !r_op_we && !r_op_ref && mem_data_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_last_p1     <= 1'b1;
      r_gnt_p1      <= 1'b0;
      r_op_we       <= 1'b0;
      r_op_ref      <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_refresh <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_din     <= '0;
      r_p0_ack      <= 1'b0;
      r_p1_ack      <= 1'b0;
      r_p0_rvalid   <= 1'b0;
      r_p1_rvalid   <= 1'b0;
      r_p0_rdata    <= '0;
      r_p1_rdata    <= '0;
    end else begin
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_refresh <= 1'b0;
      r_p0_ack      <= 1'b0;
      r_p1_ack      <= 1'b0;
      r_p0_rvalid   <= 1'b0;
      r_p1_rvalid   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_ref) begin
            r_mem_refresh <= 1'b1;
            r_op_ref      <= 1'b1;
            r_state       <= ST_ISSUE;
          end else if (w_grant_port) begin
            r_op_ref   <= 1'b0;
            r_op_we    <= w_sel_we;
            r_gnt_p1   <= w_pick_p1;
            r_last_p1  <= w_pick_p1;
            r_mem_addr <= w_sel_addr;
            r_mem_din  <= w_sel_wdata;
            r_mem_rd   <= !w_sel_we;
            r_mem_wr   <= w_sel_we;
            r_p0_ack   <= !w_pick_p1;
            r_p1_ack   <= w_pick_p1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE:     r_state <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: if (mem_busy)  r_state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (!mem_busy) r_state <= ST_IDLE;
        default:      r_state <= ST_IDLE;
      endcase
      if (w_read_return) begin
        if (r_gnt_p1) begin
          r_p1_rdata  <= mem_dout;
          r_p1_rvalid <= 1'b1;
        end else begin
          r_p0_rdata  <= mem_dout;
          r_p0_rvalid <= 1'b1;
        end
      end
    end
  end

  assign p0_ack          = r_p0_ack;
  assign p1_ack          = r_p1_ack;
  assign p0_rvalid       = r_p0_rvalid;
  assign p1_rvalid       = r_p1_rvalid;
  assign p0_rdata        = r_p0_rdata;
  assign p1_rdata        = r_p1_rdata;
  assign mem_rd          = r_mem_rd;
  assign mem_wr          = r_mem_wr;
  assign mem_refresh     = r_mem_refresh;
  assign mem_addr        = r_mem_addr;
  assign mem_din         = r_mem_din;
  assign refresh_overrun = w_overrun;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter with a simple SDRAM controller model.
`timescale 1ns/1ps
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [24:0] p0_addr = '0, p1_addr = '0;
  logic [15:0] p0_wdata = '0, p1_wdata = '0;
  logic        p0_ack, p0_rvalid, p1_ack, p1_rvalid;
  logic [15:0] p0_rdata, p1_rdata;
  logic        mem_rd, mem_wr, mem_refresh, mem_busy, refresh_overrun;
  logic [24:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout = '0;
  logic        mem_data_ready = 1'b0;

  logic        m_busy = 1'b0, force_busy = 1'b0, m_is_read = 1'b0;
  int          m_cnt = 0;
  logic [15:0] model_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          kind;  // 0 refresh, 1 port0, 2 port1
    logic        we;
    logic [24:0] addr;
    logic [15:0] data;
  } cmd_t;
  cmd_t exp_q[$];

  always #5 clk = ~clk;
  assign mem_busy = m_busy | force_busy;

  sdram_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_refresh(mem_refresh),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_data_ready(mem_data_ready), .mem_busy(mem_busy),
    .refresh_overrun(refresh_overrun)
  );

  // Controller model: busy for five cycles per command, read data on the fourth.
  always @(negedge clk) begin
    mem_data_ready = 1'b0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 1 && m_is_read) begin
        mem_data_ready = 1'b1;
        mem_dout       = model_rdata;
      end
      if (m_cnt == 0) m_busy = 1'b0;
    end else if (mem_rd || mem_wr || mem_refresh) begin
      m_busy    = 1'b1;
      m_cnt     = 5;
      m_is_read = mem_rd;
    end
  end

  function automatic cmd_t mk(input int kind, input logic we, input logic [24:0] a,
                              input logic [15:0] d);
    cmd_t e;
    e.kind = kind; e.we = we; e.addr = a; e.data = d;
    return e;
  endfunction

  function automatic int cur_cmd();
    if (mem_refresh) return 0;
    if (p0_ack) return 1;
    if (p1_ack) return 2;
    if (mem_rd || mem_wr) return 3;
    return -1;
  endfunction

  function automatic logic [46:0] sig(input int kind, input logic rd, input logic wr,
                                     input logic rf, input logic [24:0] a, input logic [15:0] d);
    logic [2:0] k3;
    k3 = 3'(kind + 1);
    if (kind == 0) return {k3, rd, wr, rf, 25'h0, 16'h0};
    return {k3, rd, wr, rf, a, d};
  endfunction

  function automatic logic [46:0] exp_sig(input cmd_t e);
    return sig(e.kind, (e.kind != 0) && !e.we, (e.kind != 0) && e.we, e.kind == 0, e.addr, e.data);
  endfunction

  function automatic logic [80:0] all_outs();
    return {p0_ack, p0_rvalid, p0_rdata, p1_ack, p1_rvalid, p1_rdata,
            mem_rd, mem_wr, mem_refresh, mem_addr, mem_din, refresh_overrun};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic busy_hold);
    p0_req = 1'b0; p1_req = 1'b0;
    force_busy = busy_hold;
    exp_q.delete();
    reset = 1'b1;
    repeat (8) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (all_outs() !== '0) $display("FAIL reset_outputs: actual=%h required=0", all_outs());
    else n_pass++;
    reset = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (all_outs() !== '0) $display("FAIL idle_after_reset: actual=%h required=0", all_outs());
    else n_pass++;
  endtask

  task automatic test_init_busy();
    cmd_t e;
    int   k;
    logic early = 1'b0, got_rv = 1'b0;
    do_reset(1'b1);
    p0_we = 1'b0; p0_addr = 25'h0000123; p0_wdata = 16'h0000;
    for (int c = 1; c <= 2000; c++) begin
      tick();
      if (c == 100) p0_req = 1'b1;
      if (cur_cmd() >= 0) early = 1'b1;
    end
    n_checks++;
    if (early !== 1'b0) $display("FAIL init_no_early_grant: actual=%b required=0", early);
    else n_pass++;
    model_rdata = 16'hBEEF;
    exp_q.push_back(mk(0, 1'b0, 25'h0, 16'h0));
    exp_q.push_back(mk(0, 1'b0, 25'h0, 16'h0));
    exp_q.push_back(mk(1, 1'b0, 25'h0000123, 16'h0000));
    force_busy = 1'b0;
    for (int c = 0; c < 300 && !got_rv; c++) begin
      tick();
      k = cur_cmd();
      if (k >= 0) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL init_cmd: actual=kind%0d required=none", k);
        else begin
          e = exp_q.pop_front();
          if (sig(k, mem_rd, mem_wr, mem_refresh, mem_addr, mem_din) !== exp_sig(e))
            $display("FAIL init_cmd: actual=%h required=%h",
                     sig(k, mem_rd, mem_wr, mem_refresh, mem_addr, mem_din), exp_sig(e));
          else begin
            n_pass++;
            $display("init cmd kind=%0d addr=%h", k, mem_addr);
          end
        end
      end
      if (p0_ack) p0_req = 1'b0;
      if (p0_rvalid) begin
        got_rv = 1'b1;
        n_checks++;
        if (p0_rdata !== 16'hBEEF) $display("FAIL init_rdata: actual=%h required=beef", p0_rdata);
        else n_pass++;
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || !got_rv)
      $display("FAIL init_complete: actual=%0d pending rv=%b required=0 pending rv=1", exp_q.size(), got_rv);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    cmd_t e;
    int   k;
    logic rv = 1'b0;
    do_reset(1'b0);
    p0_we = 1'b1; p0_addr = 25'h0000010; p0_wdata = 16'hA5A5;
    p1_we = 1'b1; p1_addr = 25'h1000020; p1_wdata = 16'h5A5A;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(1, 1'b1, 25'h0000010, 16'hA5A5));
      exp_q.push_back(mk(2, 1'b1, 25'h1000020, 16'h5A5A));
    end
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      tick();
      k = cur_cmd();
      if (p0_rvalid || p1_rvalid) rv = 1'b1;
      if (k >= 0) begin
        n_checks++;
        e = exp_q.pop_front();
        if (sig(k, mem_rd, mem_wr, mem_refresh, mem_addr, mem_din) !== exp_sig(e))
          $display("FAIL rr_cmd: actual=%h required=%h",
                   sig(k, mem_rd, mem_wr, mem_refresh, mem_addr, mem_din), exp_sig(e));
        else begin
          n_pass++;
          $display("rr write port%0d addr=%h din=%h", k - 1, mem_addr, mem_din);
        end
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL rr_complete: actual=%0d pending required=0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (rv !== 1'b0) $display("FAIL rr_write_no_rvalid: actual=%b required=0", rv);
    else n_pass++;
  endtask

  task automatic test_read_p1();
    cmd_t e;
    int   k, dr_cyc = -1, rv_cyc = -1, rv_cnt = 0;
    logic p0rv = 1'b0;
    do_reset(1'b0);
    model_rdata = 16'h1234;
    p1_we = 1'b0; p1_addr = 25'h0ABCDEF; p1_wdata = 16'h0000; p1_req = 1'b1;
    exp_q.push_back(mk(2, 1'b0, 25'h0ABCDEF, 16'h0000));
    for (int c = 0; c < 30; c++) begin
      tick();
      k = cur_cmd();
      if (k >= 0) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL p1rd_cmd: actual=kind%0d required=none", k);
        else begin
          e = exp_q.pop_front();
          if (sig(k, mem_rd, mem_wr, mem_refresh, mem_addr, mem_din) !== exp_sig(e))
            $display("FAIL p1rd_cmd: actual=%h required=%h",
                     sig(k, mem_rd, mem_wr, mem_refresh, mem_addr, mem_din), exp_sig(e));
          else n_pass++;
        end
      end
      if (p1_ack) p1_req = 1'b0;
      if (p0_rvalid) p0rv = 1'b1;
      // data_ready is still high at the sample just after the edge that registers it
      if (mem_data_ready && dr_cyc < 0) dr_cyc = c;
      if (p1_rvalid) begin
        rv_cnt++;
        if (rv_cyc < 0) begin
          rv_cyc = c;
          n_checks++;
          if (p1_rdata !== 16'h1234) $display("FAIL p1_rdata: actual=%h required=1234", p1_rdata);
          else begin
            n_pass++;
            $display("p1 read addr=0abcdef rdata=%h", p1_rdata);
          end
        end
      end
    end
    n_checks++;
    if (dr_cyc < 0 || rv_cyc != dr_cyc || rv_cnt != 1)
      $display("FAIL p1_rvalid_timing: actual=cyc%0d x%0d required=cyc%0d x1", rv_cyc, rv_cnt, dr_cyc);
    else n_pass++;
    n_checks++;
    if (p0rv !== 1'b0 || p0_rdata !== 16'h0)
      $display("FAIL p0_untouched: actual=rv%b data%h required=rv0 data0000", p0rv, p0_rdata);
    else n_pass++;
  endtask

  task automatic test_addr_hold();
    cmd_t        e;
    int          k, nacks = 0;
    logic        holding = 1'b0, seen_busy = 1'b0;
    logic [40:0] held;
    do_reset(1'b0);
    p0_we = 1'b1; p0_addr = 25'h1555555; p0_wdata = 16'hC3C3; p0_req = 1'b1;
    exp_q.push_back(mk(1, 1'b1, 25'h1555555, 16'hC3C3));
    exp_q.push_back(mk(1, 1'b0, 25'h0AAAAAA, 16'h0F0F));
    for (int c = 0; c < 100 && (exp_q.size() > 0 || holding); c++) begin
      tick();
      k = cur_cmd();
      if (k >= 0) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL hold_cmd: actual=kind%0d required=none", k);
        else begin
          e = exp_q.pop_front();
          held = {e.addr, e.data};
          holding = 1'b1; seen_busy = 1'b0;
          if (sig(k, mem_rd, mem_wr, mem_refresh, mem_addr, mem_din) !== exp_sig(e))
            $display("FAIL hold_cmd: actual=%h required=%h",
                     sig(k, mem_rd, mem_wr, mem_refresh, mem_addr, mem_din), exp_sig(e));
          else n_pass++;
        end
        nacks++;
        if (nacks == 1) begin
          p0_addr = 25'h0AAAAAA; p0_we = 1'b0; p0_wdata = 16'h0F0F;
        end else p0_req = 1'b0;
      end else if (holding) begin
        if (mem_busy) seen_busy = 1'b1;
        if (!mem_busy && seen_busy) holding = 1'b0;
        else begin
          n_checks++;
          if ({mem_addr, mem_din} !== held)
            $display("FAIL addr_hold: actual=%h required=%h", {mem_addr, mem_din}, held);
          else n_pass++;
        end
      end
    end
    p0_req = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL hold_complete: actual=%0d pending required=0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_overrun();
    logic cmd_seen = 1'b0;
    int   nref = 0;
    do_reset(1'b1);
    for (int c = 1; c <= 16 * 810 + 20; c++) begin
      tick();
      if (cur_cmd() >= 0) cmd_seen = 1'b1;
      if (c == 15 * 810 + 5) begin
        n_checks++;
        if (refresh_overrun !== 1'b0) $display("FAIL overrun_early: actual=%b required=0", refresh_overrun);
        else n_pass++;
      end
    end
    n_checks++;
    if (refresh_overrun !== 1'b1 || cmd_seen !== 1'b0)
      $display("FAIL overrun_set: actual=%b cmd=%b required=1 cmd=0", refresh_overrun, cmd_seen);
    else n_pass++;
    force_busy = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (mem_refresh) nref++;
    end
    $display("overrun drain refreshes=%0d", nref);
    n_checks++;
    if (nref != 15) $display("FAIL debt_saturate: actual=%0d refreshes required=15", nref);
    else n_pass++;
    n_checks++;
    if (refresh_overrun !== 1'b1) $display("FAIL overrun_sticky: actual=%b required=1", refresh_overrun);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    logic acked = 1'b0, rv = 1'b0;
    do_reset(1'b0);
    model_rdata = 16'h7E7E;
    p0_we = 1'b0; p0_addr = 25'h0123456; p0_wdata = 16'h0000; p0_req = 1'b1;
    for (int c = 0; c < 50 && !acked; c++) begin
      tick();
      if (p0_ack) acked = 1'b1;
    end
    p0_req = 1'b0;
    n_checks++;
    if (!acked) $display("FAIL midop_ack: actual=0 required=1");
    else n_pass++;
    tick();
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if (all_outs() !== '0) $display("FAIL midop_reset_outputs: actual=%h required=0", all_outs());
    else n_pass++;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (p0_rvalid || p1_rvalid) rv = 1'b1;
    end
    n_checks++;
    if (rv !== 1'b0 || p0_rdata !== 16'h0)
      $display("FAIL midop_no_rvalid: actual=rv%b data%h required=rv0 data0000", rv, p0_rdata);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_init_busy();
    test_round_robin();
    test_read_p1();
    test_addr_hold();
    test_overrun();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
